// File: rtl/imem_pkg.sv
// Shared constants and update-priority encoding for the synchronous
// instruction memory (imem_sync_fetch and imem_sync_ram).
package imem_pkg;

  localparam logic [31:0] IMEM_NOP_WORD  = 32'h0000_0000;
  localparam logic [31:0] IMEM_BASE_ADDR = 32'h0040_0000;
  localparam int unsigned FAULT_CNT_W    = 8;

  // Output-register update cases, listed from highest to lowest priority.
  localparam logic [2:0] UPD_RST   = 3'd0;
  localparam logic [2:0] UPD_FLUSH = 3'd1;
  localparam logic [2:0] UPD_HOLD  = 3'd2;
  localparam logic [2:0] UPD_FETCH = 3'd3;
  localparam logic [2:0] UPD_IDLE  = 3'd4;

  // Resolve the per-cycle update case; reset is active-low.
  function automatic logic [2:0] upd_sel(input logic reset_n, input logic flush,
                                         input logic stall, input logic fetch_en);
    if (!reset_n)     return UPD_RST;
    else if (flush)   return UPD_FLUSH;
    else if (stall)   return UPD_HOLD;
    else if (fetch_en) return UPD_FETCH;
    else              return UPD_IDLE;
  endfunction

endpackage

// File: rtl/imem_sync_ram.sv
// 1R1W synchronous array. A read and a write to the same index in one cycle
// return the old word. The read register only updates when re is high, so
// the last fetched word is held while the pipeline stalls.
module imem_sync_ram #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Array write; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; NBA ordering gives read-before-write on a collision.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_sync_fetch.sv
// Synchronous-read instruction memory for the IF stage: one-cycle registered
// fetch with stall/flush, base-window and alignment checking, a boot-loader
// write port and a saturating fault counter.
// Optional: define IMEM_PARITY_EN to store an even-parity bit per word and
// report parity_err on clean fetches; otherwise parity_err is tied to 0.
module imem_sync_fetch
  import imem_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH = 8,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter logic [31:0]          BASE_ADDR  = imem_pkg::IMEM_BASE_ADDR,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD  = DATA_WIDTH'(imem_pkg::IMEM_NOP_WORD)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fetch_en,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [31:0]            pc,
  output logic [DATA_WIDTH-1:0]  instr,
  output logic                   instr_valid,
  output logic [31:0]            instr_pc,
  output logic                   addr_fault,
  output logic [FAULT_CNT_W-1:0] fault_cnt,
  input  logic                   ld_we,
  input  logic [ADDR_WIDTH-1:0]  ld_addr,
  input  logic [DATA_WIDTH-1:0]  ld_data,
  output logic                   parity_err
);

`ifdef IMEM_PARITY_EN
  localparam int unsigned RAM_W = DATA_WIDTH + 1;
`else
  localparam int unsigned RAM_W = DATA_WIDTH;
`endif

  logic                   in_range;
  logic                   aligned;
  logic                   fault;
  logic [2:0]             upd;
  logic                   ram_re;
  logic                   ram_we;
  logic [RAM_W-1:0]       ram_wdata;
  logic [RAM_W-1:0]       ram_rdata;

  logic                   valid_q;
  logic                   fault_q;
  logic                   hit_q;   // instr comes from the array, not NOP_WORD
  logic [31:0]            pc_q;
  logic [FAULT_CNT_W-1:0] cnt_q;

  // Address checks and update-case decode.
  always_comb begin
    in_range = (pc[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    aligned  = (pc[1:0] == 2'b00);
    fault    = !in_range || !aligned;
    upd      = upd_sel(reset, flush, stall, fetch_en);
    ram_re   = (upd == UPD_FETCH) && !fault;
    // Loads are dropped while reset is asserted.
    ram_we   = ld_we && reset;
  end

`ifdef IMEM_PARITY_EN
  assign ram_wdata = {^ld_data, ld_data};
`else
  assign ram_wdata = ld_data;
`endif

  imem_sync_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WIDTH      (RAM_W)
  ) u_ram (
    .clk   (clk),
    .re    (ram_re),
    .raddr (pc[ADDR_WIDTH+1:2]),
    .rdata (ram_rdata),
    .we    (ram_we),
    .waddr (ld_addr),
    .wdata (ram_wdata)
  );

  // Output-state register following the reset > flush > stall > fetch > idle order.
  always_ff @(posedge clk) begin
    case (upd)
      UPD_RST: begin
        valid_q <= 1'b0;
        fault_q <= 1'b0;
        hit_q   <= 1'b0;
        pc_q    <= 32'h0;
        cnt_q   <= '0;
      end
      UPD_FLUSH: begin
        valid_q <= 1'b0;
        fault_q <= 1'b0;
        hit_q   <= 1'b0;
      end
      UPD_FETCH: begin
        valid_q <= 1'b1;
        fault_q <= fault;
        hit_q   <= !fault;
        pc_q    <= pc;
        if (fault && (cnt_q != {FAULT_CNT_W{1'b1}})) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      UPD_IDLE: begin
        valid_q <= 1'b0;
        fault_q <= 1'b0;
        hit_q   <= 1'b0;
      end
      default: ;  // UPD_HOLD: everything keeps its value
    endcase
  end

  // Output drive; the array read register supplies the word on a clean fetch.
  always_comb begin
    instr       = hit_q ? ram_rdata[DATA_WIDTH-1:0] : NOP_WORD;
    instr_valid = valid_q;
    instr_pc    = pc_q;
    addr_fault  = fault_q;
    fault_cnt   = cnt_q;
`ifdef IMEM_PARITY_EN
    // Stored bit is even parity, so the XOR of the whole entry is 0 when clean.
    parity_err  = hit_q && (^ram_rdata);
`else
    parity_err  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_imem_sync_fetch.sv
// Scoreboard bench for imem_sync_fetch: the driver pushes hand-computed
// expected outputs after each clock edge, the monitor pops and compares them
// on the following falling edge.
module tb_imem_sync_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        stall;
  logic        flush;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic        addr_fault;
  logic [7:0]  fault_cnt;
  logic        ld_we;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;
  logic        parity_err;

  typedef struct {
    logic [31:0] instr;
    logic        valid;
    logic [31:0] ipc;
    logic        fault;
    logic [7:0]  cnt;
    logic        perr;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   step_id = 0;

  imem_sync_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .stall       (stall),
    .flush       (flush),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_pc    (instr_pc),
    .addr_fault  (addr_fault),
    .fault_cnt   (fault_cnt),
    .ld_we       (ld_we),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d got=%h want=%h", name, id, act, exp);
    end
  endtask

  // Monitor: compare the DUT against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("instr",       e.id, instr,                 e.instr);
        chk("instr_valid", e.id, {31'b0, instr_valid},  {31'b0, e.valid});
        chk("instr_pc",    e.id, instr_pc,              e.ipc);
        chk("addr_fault",  e.id, {31'b0, addr_fault},   {31'b0, e.fault});
        chk("fault_cnt",   e.id, {24'b0, fault_cnt},    {24'b0, e.cnt});
        chk("parity_err",  e.id, {31'b0, parity_err},   {31'b0, e.perr});
      end
    end
  end

  function automatic exp_t mk(input logic [31:0] i, input logic v, input logic [31:0] p,
                              input logic f, input logic [7:0] c, input logic pe);
    exp_t e;
    e.instr = i; e.valid = v; e.ipc = p; e.fault = f; e.cnt = c; e.perr = pe; e.id = 0;
    return e;
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input logic rst, input logic fe, input logic st, input logic fl,
                      input logic [31:0] p, input logic we, input logic [7:0] la,
                      input logic [31:0] ld, input exp_t e);
    reset = rst; fetch_en = fe; stall = st; flush = fl; pc = p;
    ld_we = we; ld_addr = la; ld_data = ld;
    @(posedge clk);
    e.id = step_id;
    step_id++;
    sb.push_back(e);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d, input exp_t e);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, a, d, e);
  endtask

  task automatic fetch(input logic [31:0] p, input exp_t e);
    step(1'b1, 1'b1, 1'b0, 1'b0, p, 1'b0, 8'h0, 32'h0, e);
  endtask

  initial begin
    exp_t rst_e;
    exp_t idle0;
    rst_e = mk(32'h0, 1'b0, 32'h0, 1'b0, 8'h00, 1'b0);
    idle0 = rst_e;

    // Reset for two cycles.
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0, rst_e);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0, rst_e);

    // Boot-load program words; outputs stay idle.
    load(8'd0,   32'h24080000, idle0);
    load(8'd1,   32'h8d100000, idle0);
    load(8'd2,   32'haaaa5555, idle0);
    load(8'd3,   32'h12345678, idle0);
    load(8'd5,   32'h21050004, idle0);
    load(8'd255, 32'hdeadbeef, idle0);

    // Back-to-back fetches, one-cycle latency.
    fetch(32'h00400000, mk(32'h24080000, 1'b1, 32'h00400000, 1'b0, 8'h00, 1'b0));
    fetch(32'h00400004, mk(32'h8d100000, 1'b1, 32'h00400004, 1'b0, 8'h00, 1'b0));

    // Stall three cycles with a competing fetch request: everything holds.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h00400000, 1'b0, 8'h0, 32'h0,
           mk(32'h8d100000, 1'b1, 32'h00400004, 1'b0, 8'h00, 1'b0));
    end
    // Flush beats stall; instr_pc is not touched by a flush.
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h00400000, 1'b0, 8'h0, 32'h0,
         mk(32'h0, 1'b0, 32'h00400004, 1'b0, 8'h00, 1'b0));

    // Faults: misaligned, below window, just past the window (no aliasing).
    fetch(32'h00400002, mk(32'h0, 1'b1, 32'h00400002, 1'b1, 8'h01, 1'b0));
    fetch(32'h00000000, mk(32'h0, 1'b1, 32'h00000000, 1'b1, 8'h02, 1'b0));
    fetch(32'h00400400, mk(32'h0, 1'b1, 32'h00400400, 1'b1, 8'h03, 1'b0));
    // Last word of the window is in range.
    fetch(32'h004003fc, mk(32'hdeadbeef, 1'b1, 32'h004003fc, 1'b0, 8'h03, 1'b0));
    // Idle: NOP, invalid, instr_pc holds.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h00400000, 1'b0, 8'h0, 32'h0,
         mk(32'h0, 1'b0, 32'h004003fc, 1'b0, 8'h03, 1'b0));

    // Read-before-write on word 5, then the new word is visible.
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h00400014, 1'b1, 8'd5, 32'h0c100065,
         mk(32'h21050004, 1'b1, 32'h00400014, 1'b0, 8'h03, 1'b0));
    fetch(32'h00400014, mk(32'h0c100065, 1'b1, 32'h00400014, 1'b0, 8'h03, 1'b0));

    // 300 faulting fetches saturate the counter at FF.
    for (int i = 0; i < 300; i++) begin
      int c;
      c = (3 + i + 1 > 255) ? 255 : 3 + i + 1;
      fetch(32'h00400001, mk(32'h0, 1'b1, 32'h00400001, 1'b1, 8'(c), 1'b0));
    end
    // Flush does not clear the counter.
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 8'h0, 32'h0,
         mk(32'h0, 1'b0, 32'h00400001, 1'b0, 8'hff, 1'b0));

`ifdef IMEM_PARITY_EN
    // Corrupt stored bit 0 of word 3; instr shows the stored word unchanged.
    dut.u_ram.mem[3][0] = ~dut.u_ram.mem[3][0];
    fetch(32'h0040000c, mk(32'h12345679, 1'b1, 32'h0040000c, 1'b0, 8'hff, 1'b1));
    fetch(32'h00400008, mk(32'haaaa5555, 1'b1, 32'h00400008, 1'b0, 8'hff, 1'b0));
`endif

    // Set up a stall, then reset during stall with a pending load.
    fetch(32'h00400000, mk(32'h24080000, 1'b1, 32'h00400000, 1'b0, 8'hff, 1'b0));
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h00400004, 1'b1, 8'd0, 32'hffffffff, rst_e);
    // Dropped write: word 0 keeps its program value; word 5 is retained too.
    fetch(32'h00400000, mk(32'h24080000, 1'b1, 32'h00400000, 1'b0, 8'h00, 1'b0));
    fetch(32'h00400014, mk(32'h0c100065, 1'b1, 32'h00400014, 1'b0, 8'h00, 1'b0));

    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0,
         mk(32'h0, 1'b0, 32'h00400014, 1'b0, 8'h00, 1'b0));

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d want=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog time=%0t want=finish", $time);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_sync_fetch.md
Name: imem_sync_fetch

Overview:
- Parametrised, synchronous-read instruction memory for the MIPS pipeline IF stage. It is the successor to the combinational ROM.
- Adds the following on top of a plain ROM:
  - registered one-cycle fetch with stall and flush;
  - base-address range and alignment checking;
  - a runtime load port so a boot loader can write program words;
  - a saturating fault counter.

Parameters:
- ADDR_WIDTH, 8, word-index bits; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, instruction width.
- BASE_ADDR, 32'h00400000, byte address of word 0; must be aligned to 4*DEPTH.
- NOP_WORD, 32'h00000000, value driven when no valid instruction is presented.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- fetch_en  in  1  request a fetch of pc this cycle.
- stall  in  1  hold all outputs; no new fetch.
- flush  in  1  kill the in-flight/next instruction.
- pc  in  32  byte fetch address.
- instr  out  DATA_WIDTH  fetched instruction (registered).
- instr_valid  out  1  instr/instr_pc are meaningful.
- instr_pc  out  32  pc that produced instr.
- addr_fault  out  1  registered with instr; pc misaligned or out of range.
- fault_cnt  out  8  saturating count of faulting fetches.
- ld_we  in  1  load-port write enable.
- ld_addr  in  ADDR_WIDTH  load word index.
- ld_data  in  DATA_WIDTH  load data.
- parity_err  out  1  registered with instr; 0 when the feature is absent.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-low.
- Reset values (reset==0 at posedge):
  - instr=NOP_WORD, instr_valid=0, instr_pc=0, addr_fault=0, fault_cnt=0, parity_err=0.
  - Memory contents are NOT cleared.
  - ld_we is ignored while reset==0.
- Word index = pc[ADDR_WIDTH+1:2].
- In range when pc[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2].
- Misaligned when pc[1:0] != 0.
- Output-register update priority per posedge: reset > flush > stall > fetch_en > idle.
  - flush: instr=NOP_WORD, instr_valid=0, addr_fault=0, parity_err=0. Flush wins over a simultaneous stall.
  - stall (no flush): every output holds its value, including fault_cnt.
  - fetch_en, in range and aligned: instr=mem[index], instr_valid=1, instr_pc=pc, addr_fault=0.
  - fetch_en with fault: instr=NOP_WORD, instr_valid=1, instr_pc=pc, addr_fault=1, fault_cnt+=1 saturating at 8'hFF.
  - idle (fetch_en=0): instr=NOP_WORD, instr_valid=0, addr_fault=0; instr_pc holds.
- Latency: exactly 1 cycle from pc/fetch_en sampled to instr valid.
- Load port:
  - If ld_we=1 at posedge, mem[ld_addr]<=ld_data.
  - The write is independent of stall/flush/fetch_en.
  - Same-cycle fetch of the same index returns the OLD word (read-before-write). The new word is visible on the next fetch.
- No wrap-around: pc beyond the window faults; it is never aliased.
- fault_cnt is cleared only by reset.
- Reset asserted mid-stall or mid-load: outputs take reset values; the pending load is dropped.

Optional Feature:
- Macro: IMEM_PARITY_EN.
- When defined:
  - each word stores one extra even-parity bit, computed from ld_data on write;
  - on a valid in-range fetch, parity_err = (^stored_word) ^ stored_parity, registered alongside instr;
  - faulting or idle fetches give parity_err=0;
  - a parity error does not alter instr or instr_valid.
- When undefined: no parity storage; parity_err is tied to 0.

Decomposition:
- Shared package imem_pkg holds:
  - constants NOP_WORD, default BASE_ADDR, fault counter width;
  - an enum/localparams for the update-priority cases (RST, FLUSH, HOLD, FETCH, IDLE).
- One natural sub-module, imem_sync_ram: a 1R1W synchronous array with read-before-write, of width DATA_WIDTH (+1 with parity).
- imem_sync_fetch wraps the array with address check, output register and counter.

Test Plan:
- Reset and load:
  - Stimulus: hold reset=0 for 2 cycles, then release; load mem[0]=32'h24080000, mem[1]=32'h8d100000; fetch pc=0x00400000 then 0x00400004.
  - Required: instr=24080000 then 8d100000, each one cycle after pc; instr_valid=1; instr_pc matches.
- Stall and flush:
  - Stimulus: fetch 0x00400004, assert stall for 3 cycles, then stall+flush together.
  - Required: instr holds 8d100000 for 3 cycles; next cycle instr=0, instr_valid=0.
- Faults:
  - Stimulus: fetch pc=0x00400002, then pc=0x00000000.
  - Required: both give addr_fault=1, instr=0, instr_valid=1; fault_cnt=2.
  - Stimulus: 300 faulting fetches.
  - Required: fault_cnt=FF.
- Read-before-write:
  - Stimulus: in one cycle, ld_we=1, ld_addr=5, ld_data=32'h0c100065, with fetch of 0x00400014 (old word 32'h21050004).
  - Required: instr=21050004; the next fetch of the same pc gives 0c100065.
- Parity (IMEM_PARITY_EN only):
  - Stimulus: force a flip of stored bit 0 of word 3, then fetch 0x0040000C.
  - Required: parity_err=1, instr_valid=1.
  - Stimulus: fetch a clean word.
  - Required: parity_err=0.
- Reset mid-operation:
  - Stimulus: assert reset=0 while stall=1 and ld_we=1.
  - Required: all outputs reset, write dropped, earlier memory contents retained.
